instr_fetch_unit: RTL and testbench

Instruction fetch stage that produces the instruction stream consumed by `Control_Unit`. It holds the PC, issues word reads to a synchronous instruction memory and buffers returned words in a 2-entry FIFO. It presents the words to decode with a valid/ready handshake, including a pre-sliced `opcode` for the control unit. Branch and jump redirects from execute flush the buffer and restart fetch at the target.

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC, issues word reads to a
//            synchronous instruction memory (data returns one cycle after the
//            request), buffers returned words in a 2-entry FIFO and presents
//            them to decode over a valid/ready handshake. Redirects from
//            execute flush the buffer and restart fetch at the target.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst_n          - synchronous active-low reset
//   imem_req       - read request this cycle
//   imem_addr      - word-aligned byte address of the request
//   imem_rdata     - read data, valid the cycle after the request
//   instr_valid    - FIFO head holds a valid instruction
//   instr_ready    - decode accepts the head this cycle
//   instr          - head instruction word
//   instr_pc       - PC of the head instruction
//   opcode         - instr[6:0], for the control unit
//   redirect_valid - branch taken / jump: flush and restart fetch
//   redirect_pc    - redirect target address
//   fetch_fault    - sticky flag, set by a misaligned redirect target
// ============================================================================
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;   // address of the in-flight request
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] fifo_instr_q [2];
  logic [XLEN-1:0] fifo_instr_d [2];
  logic [XLEN-1:0] fifo_pc_q    [2];
  logic [XLEN-1:0] fifo_pc_d    [2];
  logic            head_q,     head_d;
  logic [1:0]      count_q,    count_d;
  logic            fault_q,    fault_d;

  logic       pop;
  logic       pop_eff;
  logic       push;
  logic       issue;
  logic       tail;
  logic [2:0] occupancy;

  assign instr_valid = rst_n && (count_q != 2'd0);
  assign pop         = instr_valid && instr_ready;
  // A redirect overrides the handshake: the head is not consumed.
  assign pop_eff     = pop && !redirect_valid;
  assign push        = inflight_q && !redirect_valid;

  // Slots that will be occupied once the in-flight response lands. Never
  // underflows: pop implies count_q >= 1.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = rst_n && !redirect_valid && !fault_q && (occupancy < 3'd2);

  // count_q + inflight_q <= 2 guarantees a push never sees a full FIFO, so the
  // tail is simply the slot after the head when one entry is present.
  assign tail = head_q ^ count_q[0];

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr       = fifo_instr_q[head_q];
  assign instr_pc    = fifo_pc_q[head_q];
  assign opcode      = instr[6:0];
  assign fetch_fault = fault_q;

  always_comb begin
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    inflight_d   = 1'b0;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    head_d       = head_q;
    count_d      = count_q;
    fault_d      = fault_q;

    if (redirect_valid) begin
      // Flush: buffered entries and the response arriving now are dropped.
      count_d = 2'd0;
      head_d  = 1'b0;
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
    end else begin
      if (issue) begin
        pc_d       = pc_q + C_PC_STEP;   // wraps modulo 2^XLEN
        req_addr_d = pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        fifo_instr_d[tail] = imem_rdata;
        fifo_pc_d[tail]    = req_addr_q;
      end
      if (pop_eff) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop_eff};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      inflight_q   <= 1'b0;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
      head_q       <= 1'b0;
      count_q      <= 2'd0;
      fault_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      inflight_q   <= inflight_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      head_q       <= head_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. The stimulus process
//            drives directed cycles, checks request/valid/fault timing and
//            queues the PCs decode is expected to accept; a monitor pops the
//            queue on every accepted instruction and compares pc/instr/opcode.
//            Memory returns addr ^ 32'hA5A5_0000 one cycle after a request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] C_XOR = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mon_pc;
  logic [31:0] mon_ins;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory model.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ C_XOR;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every instruction accepted by decode must match the queue head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr actual_pc=%h expected=none t=%0t", instr_pc, $time);
      end else begin
        mon_pc  = exp_q.pop_front();
        mon_ins = mon_pc ^ C_XOR;
        check("mon_instr_pc", instr_pc, mon_pc);
        check("mon_instr", instr, mon_ins);
        check("mon_opcode", {25'b0, opcode}, {25'b0, mon_ins[6:0]});
      end
    end
  end

  // One cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic rv,
                     input logic [31:0] rp, input logic e_req, input logic [31:0] e_addr,
                     input logic e_vld, input logic e_flt, input logic chk_flt);
    @(posedge clk);
    #1;
    rst_n          = r;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(negedge clk);
    check({tag, "_req"}, {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) check({tag, "_addr"}, imem_addr, e_addr);
    check({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, e_vld});
    if (chk_flt) check({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, e_flt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values.
    cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_opcode", {25'b0, opcode}, 32'h0);

    // Free run with instr_ready = 1: one instruction per cycle from cycle 2.
    for (int k = 0; k < 10; k++) exp_q.push_back(32'(4 * k));
    for (int k = 0; k < 12; k++)
      cyc($sformatf("A%0d", k), 1, 1, 0, 0, 1, 32'(4 * k), k >= 2, 0, 1);

    // Reset, then backpressure from cycle 0.
    cyc("B_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    cyc("B0", 1, 0, 0, 0, 1, 32'h0, 0, 0, 1);
    cyc("B1", 1, 0, 0, 0, 1, 32'h4, 0, 0, 1);
    for (int k = 2; k < 5; k++) begin
      cyc($sformatf("B%0d", k), 1, 0, 0, 0, 0, 0, 1, 0, 1);
      check($sformatf("B%0d_head_pc", k), instr_pc, 32'h0);
      check($sformatf("B%0d_head_instr", k), instr, C_XOR);
    end
    cyc("B5", 1, 1, 0, 0, 1, 32'h8,  1, 0, 1);
    cyc("B6", 1, 1, 0, 0, 1, 32'hC,  1, 0, 1);
    cyc("B7", 1, 1, 0, 0, 1, 32'h10, 1, 0, 1);
    cyc("B8", 1, 0, 0, 0, 0, 0,      1, 0, 1);

    // Redirect with a full FIFO (heads 12 and 16 must never be seen).
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    cyc("R0", 1, 1, 1, 32'h100, 0, 0, 1, 0, 1);
    cyc("R1", 1, 1, 0, 0, 1, 32'h100, 0, 0, 1);
    cyc("R2", 1, 1, 0, 0, 1, 32'h104, 0, 0, 1);
    cyc("R3", 1, 1, 0, 0, 1, 32'h108, 1, 0, 1);
    cyc("R4", 1, 1, 0, 0, 1, 32'h10C, 1, 0, 1);

    // Redirect coinciding with a pop and a push: head 0x108 is dropped.
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    cyc("P0", 1, 1, 1, 32'h200, 0, 0, 1, 0, 1);
    cyc("P1", 1, 1, 0, 0, 1, 32'h200, 0, 0, 1);
    cyc("P2", 1, 1, 0, 0, 1, 32'h204, 0, 0, 1);
    cyc("P3", 1, 1, 0, 0, 1, 32'h208, 1, 0, 1);
    cyc("P4", 1, 1, 0, 0, 1, 32'h20C, 1, 0, 1);

    // Misaligned redirect: sticky fault, no more requests.
    cyc("F0", 1, 1, 1, 32'h102, 0, 0, 1, 0, 1);
    for (int k = 1; k < 5; k++)
      cyc($sformatf("F%0d", k), 1, 1, 0, 0, 0, 0, 0, 1, 1);

    // One-cycle reset clears the fault and restarts at RESET_PC.
    cyc("X_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("X0", 1, 1, 0, 0, 1, 32'h0, 0, 0, 1);
    cyc("X1", 1, 1, 0, 0, 1, 32'h4, 0, 0, 1);

    // PC wrap: redirect to the top word, next request is to address 0.
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    cyc("W0", 1, 1, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, 1);
    cyc("W1", 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    cyc("W2", 1, 1, 0, 0, 1, 32'h0, 0, 0, 1);
    cyc("W3", 1, 1, 0, 0, 1, 32'h4, 1, 0, 1);
    cyc("W4", 1, 1, 0, 0, 1, 32'h8, 1, 0, 1);
    cyc("W5", 1, 1, 0, 0, 1, 32'hC, 1, 0, 1);
    cyc("W6", 1, 0, 0, 0, 0, 0,     1, 0, 1);
    cyc("W7", 1, 0, 0, 0, 0, 0,     1, 0, 1);

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
